pulse_train_sequencer: RTL
==========================

Name: pulse_train_sequencer

Overview:
Run-time controller that sequences bursts of pulses on one output line. It replaces fixed-parameter pulse generation with a configuration latched at start: pulse count, high time and low time. It has a start/busy/done handshake and an abort. It sits between the control logic and the pulse-driven front end.

Parameters:
CNT_W, 8, width of pulse-count config and completed-pulse counter
DUR_W, 8, width of high/low duration configs (cycles)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new train; sampled only in IDLE
abort  input  1  terminate the current train
cfg_n_pulses  input  CNT_W  pulses per train; latched on accepted start
cfg_high  input  DUR_W  pulse high time in cycles; latched on accepted start
cfg_low  input  DUR_W  low time between pulses in cycles; latched on accepted start
pulse  output  1  registered pulse output
busy  output  1  train in progress
done  output  1  one-cycle strobe when a train completes normally
aborted  output  1  one-cycle strobe when a train is terminated by abort
cfg_err  output  1  one-cycle strobe when a start is rejected
pulse_cnt  output  CNT_W  pulses fully emitted in the current or last train

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - pulse, busy, done, aborted, cfg_err and pulse_cnt are all 0.
  - Latched config is 0.
- States: IDLE, HIGH, LOW. All outputs are registered.
- Start acceptance, in IDLE:
  - start=1 with cfg_n_pulses!=0 and cfg_high!=0 is accepted.
  - On acceptance: latch config, clear pulse_cnt, clear the phase counter, enter HIGH.
  - In the next cycle pulse=1 and busy=1 (latency 1 cycle).
  - start with cfg_n_pulses=0 or cfg_high=0 is rejected: cfg_err=1 for one cycle, state stays IDLE, pulse_cnt is unchanged.
- HIGH:
  - pulse=1 for exactly cfg_high cycles.
  - On the last high cycle, pulse_cnt increments.
  - If pulse_cnt+1 equals n_pulses, go to IDLE. Next cycle: pulse=0, busy=0, done=1.
  - Otherwise go to LOW.
- LOW:
  - pulse=0, busy=1, for exactly cfg_low cycles, then back to HIGH.
  - cfg_low=0 is clamped to 1 cycle so successive pulses stay separated.
- No trailing LOW phase after the last pulse.
- Train length from accepted start to done strobe: n*high + (n-1)*max(low,1) + 1 cycles.
- start while busy is ignored: no effect, no error.
- Config inputs are don't-care except in the cycle start is accepted.
- Abort:
  - abort=1 in HIGH or LOW: next cycle pulse=0, busy=0, aborted=1, state IDLE, no done.
  - pulse_cnt holds the number of pulses fully emitted; a partial pulse is not counted.
  - abort in IDLE is ignored. If start is also high, abort wins: start is dropped and no strobes are raised.
- Abort has priority over a phase transition in the same cycle, including the last high cycle: no done, and pulse_cnt is not incremented.
- Phase counter: DUR_W bits, reloaded at every phase change. A maximal config (2^DUR_W-1) must not wrap.
- pulse_cnt does not wrap: n_pulses ≤ 2^CNT_W-1, and the train ends at equality.
- done, aborted and cfg_err are mutually exclusive and last exactly one cycle.
- Async reset mid-train forces the reset values immediately. After release, the block sits in IDLE until a new start.

Test Plan:
- Reset then start with N=10, high=2, low=2 (start in cycle 0):
  - pulse=1 in cycles 1-2, 5-6, …, 37-38.
  - done=1 in cycle 39, busy=0 in cycle 39, pulse_cnt=10.
  - Bench checks every cycle.
- start with N=3, high=1, low=0: pulse=1 in cycles 1, 3, 5; done in cycle 6; pulse_cnt=3.
- start with N=0, then with high=0:
  - cfg_err=1 for one cycle each.
  - busy and pulse stay 0, pulse_cnt keeps its prior value.
- N=5, high=4, low=3, abort asserted in the 3rd high cycle of pulse 2:
  - Next cycle: pulse=0, busy=0, aborted=1, no done, pulse_cnt=1.
  - A restart then runs a full 5-pulse train normally.
- Mid-train reconfig and start:
  - During a train, toggle start with changed cfg_* values: the train timing is unchanged.
  - In IDLE, start and abort in the same cycle: no activity and no strobes.
- Boundary widths: DUR_W=4 with high=15, low=15, N=2 gives pulses in cycles 1-15 and 31-45, then done in cycle 46.
- Async reset: drop rst_n mid-LOW with the clock stopped; all outputs go to 0 immediately.

Source files
------------

// File: rtl/pulse_train_sequencer.sv
// Burst pulse generator: pulse count, high time and low time are latched on an
// accepted start and sequenced through IDLE/HIGH/LOW with done/abort strobes.
module pulse_train_sequencer #(
  parameter int CNT_W = 8,
  parameter int DUR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_n_pulses,
  input  logic [DUR_W-1:0] cfg_high,
  input  logic [DUR_W-1:0] cfg_low,
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             cfg_err,
  output logic [CNT_W-1:0] pulse_cnt
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [DUR_W-1:0] high_q, high_d;
  logic [DUR_W-1:0] low_q, low_d;
  // Phase counter holds the cycles remaining after the current one, so a
  // full-scale duration loads 2^DUR_W-2 and never wraps.
  logic [DUR_W-1:0] ph_q, ph_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             cfg_err_q, cfg_err_d;
  logic [DUR_W-1:0] low_reload;
  logic [CNT_W-1:0] cnt_inc;

  // low=0 is stretched to one cycle to keep successive pulses apart
  assign low_reload = (low_q <= DUR_W'(1)) ? '0 : low_q - DUR_W'(1);
  assign cnt_inc    = cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    high_d    = high_q;
    low_d     = low_q;
    ph_d      = ph_q;
    cnt_d     = cnt_q;
    pulse_d   = pulse_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    cfg_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        pulse_d = 1'b0;
        busy_d  = 1'b0;
        if (start && !abort) begin
          if (cfg_n_pulses != '0 && cfg_high != '0) begin
            n_d     = cfg_n_pulses;
            high_d  = cfg_high;
            low_d   = cfg_low;
            cnt_d   = '0;
            ph_d    = cfg_high - DUR_W'(1);
            state_d = HIGH;
            pulse_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      HIGH: begin
        if (abort) begin
          state_d   = IDLE;
          pulse_d   = 1'b0;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
        end else if (ph_q == '0) begin
          cnt_d   = cnt_inc;
          pulse_d = 1'b0;
          if (cnt_inc == n_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = LOW;
            ph_d    = low_reload;
          end
        end else begin
          ph_d = ph_q - DUR_W'(1);
        end
      end
      LOW: begin
        if (abort) begin
          state_d   = IDLE;
          pulse_d   = 1'b0;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
        end else if (ph_q == '0) begin
          state_d = HIGH;
          pulse_d = 1'b1;
          ph_d    = high_q - DUR_W'(1);
        end else begin
          ph_d = ph_q - DUR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        pulse_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      n_q       <= '0;
      high_q    <= '0;
      low_q     <= '0;
      ph_q      <= '0;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      high_q    <= high_d;
      low_q     <= low_d;
      ph_q      <= ph_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign pulse     = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign cfg_err   = cfg_err_q;
  assign pulse_cnt = cnt_q;

endmodule
